// File: rtl/cntr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cntr_pkg
//  Description : Shared types and helpers for the up/down counter slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package cntr_pkg;

    typedef enum logic {
        CNT_UP   = 1'b0,
        CNT_DOWN = 1'b1
    } cnt_dir_e;

    // Prescaler counter width; never narrower than one bit.
    function automatic int pcnt_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage : cntr_pkg
`default_nettype wire

// File: rtl/cntr_prescale.sv
`default_nettype none
// ============================================================================
//  Module      : cntr_prescale
//  Description : Divides enabled cycles by PRESCALE, emitting one tick per
//                PRESCALE enabled cycles. clr restarts the period.
//  Revision    : 1.0 - initial release
// ============================================================================
module cntr_prescale
    import cntr_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = pcnt_width(PRESCALE);

    generate
        if (PRESCALE == 1) begin : g_bypass
            logic unused_ok;
            assign unused_ok = ^{clk, reset, clr};
            assign tick      = en;
        end else begin : g_count
            localparam logic [PW-1:0] C_LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] pcnt_q;
            logic [PW-1:0] pcnt_d;

            always_comb begin
                pcnt_d = pcnt_q;
                if (clr) begin
                    pcnt_d = '0;
                end else if (en) begin
                    pcnt_d = (pcnt_q == C_LAST) ? '0 : pcnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pcnt_q <= '0;
                end else begin
                    pcnt_q <= pcnt_d;
                end
            end

            assign tick = en & ~clr & (pcnt_q == C_LAST);
        end
    endgenerate

endmodule : cntr_prescale
`default_nettype wire

// File: rtl/cntr_ud_mod.sv
`default_nettype none
// ============================================================================
//  Module      : cntr_ud_mod
//  Description : Parametrised modulo up/down counter with enable, clamped
//                parallel load, optional saturation and input prescaler.
//  Revision    : 1.0 - initial release
// ============================================================================
module cntr_ud_mod
    import cntr_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             ud,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    // Upper end of the range as a WIDTH-bit constant, so MODULUS == 2**WIDTH
    // never needs a wider comparison.
    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULUS - 1);

    generate
        if (WIDTH < 1) begin : g_chk_width
            $error("cntr_ud_mod: WIDTH must be >= 1");
        end
        if ((MODULUS < 2) || (longint'(MODULUS) > (64'd1 << WIDTH))) begin : g_chk_mod
            $error("cntr_ud_mod: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
        if ((SATURATE != 0) && (SATURATE != 1)) begin : g_chk_sat
            $error("cntr_ud_mod: SATURATE must be 0 or 1");
        end
        if (PRESCALE < 1) begin : g_chk_pre
            $error("cntr_ud_mod: PRESCALE must be >= 1");
        end
    endgenerate

    cnt_dir_e         dir;
    logic             step;
    logic             at_end;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;

    assign dir = cnt_dir_e'(ud);

    cntr_prescale #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (load),
        .tick  (step)
    );

    // Terminal count doubles as the boundary flag for the step about to fire.
    assign at_end = (dir == CNT_UP) ? (cnt_q == C_MAX) : (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (load) begin
            cnt_d = (d > C_MAX) ? C_MAX : d;
        end else if (step) begin
            ovf_d = at_end;
            if (at_end) begin
                if (SATURATE == 0) begin
                    cnt_d = (dir == CNT_UP) ? '0 : C_MAX;
                end
            end else begin
                cnt_d = (dir == CNT_UP) ? cnt_q + 1'b1 : cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = cnt_q;
    assign tc  = at_end;
    assign ovf = ovf_q;

endmodule : cntr_ud_mod
`default_nettype wire
